kamus_wb_port_arbiter: RTL and testbench
========================================

// Module: kamus_wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between two sources.
//  - In-order pipeline writeback: output of the WB stage.
//  - Long-latency unit (LU): the multi-cycle MUL/DIV unit.
//  Pipeline has priority. A starvation counter forces an LU grant after STARVE_LIMIT lost cycles.
//  Keeps a pending-rd scoreboard of LU destinations for the hazard unit.
//  The write port is registered; it drives the regfile write interface.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive cycles LU may be denied before a forced grant (legal range >=1)
//  XLEN          32  data width
// PORTS
//  clk_i              in   1     clock
//  rst_ni             in   1     synchronous, active-low reset
//  pipe_valid_i       in   1     pipeline WB slot valid
//  pipe_wr_en_i       in   1     pipeline slot writes regfile
//  pipe_rd_i          in   5     pipeline destination
//  pipe_data_i        in   XLEN  pipeline write data
//  pipe_ready_o       out  1     slot accepted; low = stall pipeline
//  lu_issue_valid_i   in   1     LU op issued this cycle
//  lu_issue_rd_i      in   5     destination of issued LU op
//  lu_valid_i         in   1     LU result available
//  lu_rd_i            in   5     LU result destination
//  lu_data_i          in   XLEN  LU result data
//  lu_ready_o         out  1     LU result accepted
//  rd_pending_o       out  32    bit n set = LU write to xn outstanding
//  regfile_wr_en_o    out  1     registered write enable
//  rd_addr_o          out  5     registered write address
//  wb_data_o          out  XLEN  registered write data
// BEHAVIOUR
//  - Reset (rst_ni=0 at clk edge): all outputs 0, state=PIPE_PRIO, starve_cnt=0, scoreboard=0.
//    Reset mid-operation discards any in-flight LU result and all pending bits.
//  - pipe_need = pipe_valid_i & pipe_wr_en_i.
//    A pipe slot with wr_en=0 never uses the port.
//    pipe_ready_o=1 for that slot in every state.
//  - FSM state PIPE_PRIO:
//    - pipe_need: grant pipe; pipe_ready_o=1, lu_ready_o=0.
//    - No pipe_need: lu_ready_o=lu_valid_i; pipe_ready_o=1.
//  - FSM state LU_FORCED:
//    - lu_valid_i: grant LU; pipe_ready_o=~pipe_need.
//    - No lu_valid_i: behave as PIPE_PRIO.
//    - Always return to PIPE_PRIO next cycle.
//  - starve_cnt:
//    - +1 each cycle with lu_valid_i & ~lu_ready_o; saturates at STARVE_LIMIT.
//    - Cleared on LU grant or when lu_valid_i=0.
//    - Transition PIPE_PRIO->LU_FORCED when the incremented value equals STARVE_LIMIT.
//  - Write port, 1-cycle latency from accept:
//    - regfile_wr_en_o = granted source's write & (rd!=0).
//    - rd_addr_o/wb_data_o load from the granted source; they hold when nothing is granted.
//    - An x0 write is accepted (ready=1) and dropped (wr_en_o=0).
//  - Scoreboard:
//    - Set bit lu_issue_rd_i on lu_issue_valid_i when rd!=0.
//    - Clear bit lu_rd_i on an LU accept.
//    - Same cycle set and clear of the same rd: set wins.
//    - Bit 0 is always 0. rd_pending_o is registered (visible next cycle).
//  - At most one grant per cycle; never both ready signals high with both needing the port.
// TESTING
//  - Reset: drive random inputs with rst_ni=0 -> every output 0 on the following cycle.
//    A pending LU result with rst_ni=0 -> never written.
//  - Pipe only: pipe_valid=1, wr_en=1, rd=5, data=0xDEADBEEF.
//    -> cycle+1: regfile_wr_en_o=1, rd_addr_o=5, wb_data_o=0xDEADBEEF.
//  - Idle slot: pipe wr_en=0 with lu_valid=1, rd=7, data=0x12.
//    -> lu_ready_o=1 same cycle; next cycle write x7=0x12.
//  - Starvation, STARVE_LIMIT=4: pipe_need every cycle, lu_valid held, rd=9.
//    -> lu_ready_o=0 for 4 cycles, then pipe_ready_o=0 and lu_ready_o=1 for exactly 1 cycle.
//    -> x9 written; pipe resumes the next cycle.
//  - Scoreboard: issue rd=3 -> rd_pending_o[3]=1.
//    LU result rd=3 accepted while a new issue rd=3 in the same cycle -> bit stays 1.
//    Issue rd=0 -> bit 0 stays 0.
//  - x0: LU result rd=0 -> lu_ready_o=1, regfile_wr_en_o stays 0.

Source files
------------

// File: rtl/kamus_wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. the
// long-latency MUL/DIV unit, with anti-starvation and a pending-rd scoreboard.
module kamus_wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pipe_valid_i,
  input  logic            pipe_wr_en_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_data_i,
  output logic            pipe_ready_o,
  input  logic            lu_issue_valid_i,
  input  logic [4:0]      lu_issue_rd_i,
  input  logic            lu_valid_i,
  input  logic [4:0]      lu_rd_i,
  input  logic [XLEN-1:0] lu_data_i,
  output logic            lu_ready_o,
  output logic [31:0]     rd_pending_o,
  output logic            regfile_wr_en_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] wb_data_o
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    PIPE_PRIO = 1'b0,
    LU_FORCED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [CW:0]     starve_inc;
  logic [31:0]     sb_q, sb_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic pipe_need;
  logic grant_pipe, grant_lu;

  assign pipe_need  = pipe_valid_i & pipe_wr_en_i;
  assign starve_inc = {1'b0, starve_cnt_q} + {{CW{1'b0}}, 1'b1};

  // Arbitration. Readies are held low during reset so nothing is accepted
  // (and hence nothing is written) while rst_ni is asserted.
  always_comb begin
    grant_pipe   = 1'b0;
    grant_lu     = 1'b0;
    pipe_ready_o = 1'b0;
    lu_ready_o   = 1'b0;
    if (rst_ni) begin
      if (state_q == LU_FORCED && lu_valid_i) begin
        grant_lu     = 1'b1;
        lu_ready_o   = 1'b1;
        pipe_ready_o = ~pipe_need;
      end else if (pipe_need) begin
        grant_pipe   = 1'b1;
        pipe_ready_o = 1'b1;
      end else begin
        grant_lu     = lu_valid_i;
        lu_ready_o   = lu_valid_i;
        pipe_ready_o = 1'b1;
      end
    end
  end

  // Starvation counter and FSM next state
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    state_d      = PIPE_PRIO;
    if (grant_lu || !lu_valid_i) begin
      starve_cnt_d = '0;
    end else begin
      if (starve_inc >= (CW+1)'(STARVE_LIMIT))
        starve_cnt_d = CW'(STARVE_LIMIT);
      else
        starve_cnt_d = starve_inc[CW-1:0];
      if (state_q == PIPE_PRIO && starve_inc == (CW+1)'(STARVE_LIMIT))
        state_d = LU_FORCED;
    end
  end

  // Write port: address/data hold when idle, enable pulses per grant
  always_comb begin
    wr_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wb_data_d = wb_data_q;
    if (grant_pipe) begin
      wr_en_d   = (pipe_rd_i != 5'd0);
      rd_addr_d = pipe_rd_i;
      wb_data_d = pipe_data_i;
    end else if (grant_lu) begin
      wr_en_d   = (lu_rd_i != 5'd0);
      rd_addr_d = lu_rd_i;
      wb_data_d = lu_data_i;
    end
  end

  // Scoreboard: clear first so a same-cycle issue to the same rd wins
  always_comb begin
    sb_d = sb_q;
    if (grant_lu)
      sb_d[lu_rd_i] = 1'b0;
    if (lu_issue_valid_i && lu_issue_rd_i != 5'd0)
      sb_d[lu_issue_rd_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= PIPE_PRIO;
      starve_cnt_q <= '0;
      sb_q         <= '0;
      wr_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      sb_q         <= sb_d;
      wr_en_q      <= wr_en_d;
      rd_addr_q    <= rd_addr_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign rd_pending_o    = sb_q;
  assign regfile_wr_en_o = wr_en_q;
  assign rd_addr_o       = rd_addr_q;
  assign wb_data_o       = wb_data_q;

endmodule

// File: tb/tb_kamus_wb_port_arbiter.sv
// Directed bench for kamus_wb_port_arbiter (STARVE_LIMIT=4, XLEN=32).
module tb_kamus_wb_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pipe_valid_i, pipe_wr_en_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        pipe_ready_o;
  logic        lu_issue_valid_i;
  logic [4:0]  lu_issue_rd_i;
  logic        lu_valid_i;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic [31:0] rd_pending_o;
  logic        regfile_wr_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wb_data_o;

  int errors = 0;
  int checks = 0;

  kamus_wb_port_arbiter #(.STARVE_LIMIT(4), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pipe_valid_i(pipe_valid_i), .pipe_wr_en_i(pipe_wr_en_i),
    .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i), .pipe_ready_o(pipe_ready_o),
    .lu_issue_valid_i(lu_issue_valid_i), .lu_issue_rd_i(lu_issue_rd_i),
    .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
    .lu_ready_o(lu_ready_o), .rd_pending_o(rd_pending_o),
    .regfile_wr_en_o(regfile_wr_en_o), .rd_addr_o(rd_addr_o), .wb_data_o(wb_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    pipe_valid_i = 0; pipe_wr_en_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
    lu_issue_valid_i = 0; lu_issue_rd_i = 0;
    lu_valid_i = 0; lu_rd_i = 0; lu_data_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    for (int i = 0; i < 4; i++) begin
      pipe_valid_i = 1'($urandom); pipe_wr_en_i = 1'($urandom);
      pipe_rd_i = 5'($urandom); pipe_data_i = $urandom;
      lu_issue_valid_i = 1'b1; lu_issue_rd_i = 5'($urandom_range(1, 31));
      lu_valid_i = 1'b1; lu_rd_i = 5'($urandom_range(1, 31)); lu_data_i = $urandom;
      step();
      checks++;
      if ({regfile_wr_en_o, rd_addr_o, wb_data_o, rd_pending_o, pipe_ready_o, lu_ready_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d got we=%b rd=%0d data=%h pend=%h prdy=%b lrdy=%b required all 0",
                 i, regfile_wr_en_o, rd_addr_o, wb_data_o, rd_pending_o, pipe_ready_o, lu_ready_o);
      end
    end
    // Pending LU result seen only during reset must never be written
    idle();
    rst_ni = 1;
    step();
    checks++;
    if (regfile_wr_en_o !== 1'b0 || rd_pending_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_lu_dropped got we=%b pend=%h required we=0 pend=0", regfile_wr_en_o, rd_pending_o);
    end
  endtask

  task automatic test_pipe_only();
    idle();
    pipe_valid_i = 1; pipe_wr_en_i = 1; pipe_rd_i = 5; pipe_data_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (pipe_ready_o !== 1'b1 || lu_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL pipe_ready got prdy=%b lrdy=%b required 1/0", pipe_ready_o, lu_ready_o);
    end
    step();
    idle();
    checks++;
    if (regfile_wr_en_o !== 1'b1 || rd_addr_o !== 5'd5 || wb_data_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pipe_write got we=%b rd=%0d data=%h required 1/5/deadbeef", regfile_wr_en_o, rd_addr_o, wb_data_o);
    end
    step();
    checks++;
    if (regfile_wr_en_o !== 1'b0 || rd_addr_o !== 5'd5 || wb_data_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL port_hold got we=%b rd=%0d data=%h required 0/5/deadbeef", regfile_wr_en_o, rd_addr_o, wb_data_o);
    end
  endtask

  task automatic test_idle_slot();
    idle();
    pipe_valid_i = 1; pipe_wr_en_i = 0; pipe_rd_i = 4; pipe_data_i = 32'hAAAA;
    lu_valid_i = 1; lu_rd_i = 7; lu_data_i = 32'h12;
    #1;
    checks++;
    if (lu_ready_o !== 1'b1 || pipe_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_slot_ready got lrdy=%b prdy=%b required 1/1", lu_ready_o, pipe_ready_o);
    end
    step();
    idle();
    checks++;
    if (regfile_wr_en_o !== 1'b1 || rd_addr_o !== 5'd7 || wb_data_o !== 32'h12) begin
      errors++;
      $display("FAIL idle_slot_write got we=%b rd=%0d data=%h required 1/7/12", regfile_wr_en_o, rd_addr_o, wb_data_o);
    end
  endtask

  task automatic test_starvation();
    idle();
    pipe_valid_i = 1; pipe_wr_en_i = 1;
    lu_valid_i = 1; lu_rd_i = 9; lu_data_i = 32'h99;
    for (int c = 0; c < 4; c++) begin
      pipe_rd_i = 5'(10 + c); pipe_data_i = 32'h100 + c;
      #1;
      checks++;
      if (lu_ready_o !== 1'b0 || pipe_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL starve_denied cyc%0d got lrdy=%b prdy=%b required 0/1", c, lu_ready_o, pipe_ready_o);
      end
      step();
      checks++;
      if (regfile_wr_en_o !== 1'b1 || rd_addr_o !== 5'(10 + c)) begin
        errors++;
        $display("FAIL starve_pipe_write cyc%0d got we=%b rd=%0d required 1/%0d", c, regfile_wr_en_o, rd_addr_o, 10 + c);
      end
    end
    pipe_rd_i = 14; pipe_data_i = 32'h104;
    #1;
    checks++;
    if (lu_ready_o !== 1'b1 || pipe_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL starve_forced got lrdy=%b prdy=%b required 1/0", lu_ready_o, pipe_ready_o);
    end
    step();
    lu_valid_i = 0;
    checks++;
    if (regfile_wr_en_o !== 1'b1 || rd_addr_o !== 5'd9 || wb_data_o !== 32'h99) begin
      errors++;
      $display("FAIL starve_lu_write got we=%b rd=%0d data=%h required 1/9/99", regfile_wr_en_o, rd_addr_o, wb_data_o);
    end
    #1;
    checks++;
    if (pipe_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL starve_pipe_resume got prdy=%b required 1", pipe_ready_o);
    end
    step();
    checks++;
    if (regfile_wr_en_o !== 1'b1 || rd_addr_o !== 5'd14 || wb_data_o !== 32'h104) begin
      errors++;
      $display("FAIL starve_pipe_after got we=%b rd=%0d data=%h required 1/14/104", regfile_wr_en_o, rd_addr_o, wb_data_o);
    end
  endtask

  // Dropping lu_valid clears the count: 3 denials, a gap, then 4 more denials
  task automatic test_starve_clear();
    idle();
    pipe_valid_i = 1; pipe_wr_en_i = 1; pipe_rd_i = 20; pipe_data_i = 32'h20;
    lu_rd_i = 21; lu_data_i = 32'h21;
    for (int c = 0; c < 8; c++) begin
      lu_valid_i = (c != 3);
      #1;
      checks++;
      if (lu_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL starve_clear cyc%0d got lrdy=%b required 0", c, lu_ready_o);
      end
      step();
    end
    #1;
    checks++;
    if (lu_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL starve_clear_forced got lrdy=%b required 1", lu_ready_o);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_scoreboard();
    idle();
    lu_issue_valid_i = 1; lu_issue_rd_i = 3;
    step();
    idle();
    checks++;
    if (rd_pending_o !== 32'h0000_0008) begin
      errors++;
      $display("FAIL sb_set got %h required 00000008", rd_pending_o);
    end
    lu_valid_i = 1; lu_rd_i = 3; lu_data_i = 32'h33;
    lu_issue_valid_i = 1; lu_issue_rd_i = 3;
    step();
    idle();
    checks++;
    if (rd_pending_o !== 32'h0000_0008 || regfile_wr_en_o !== 1'b1 || rd_addr_o !== 5'd3) begin
      errors++;
      $display("FAIL sb_set_wins got pend=%h we=%b rd=%0d required 00000008/1/3", rd_pending_o, regfile_wr_en_o, rd_addr_o);
    end
    lu_valid_i = 1; lu_rd_i = 3; lu_data_i = 32'h34;
    step();
    idle();
    checks++;
    if (rd_pending_o !== 32'h0) begin
      errors++;
      $display("FAIL sb_clear got %h required 00000000", rd_pending_o);
    end
    lu_issue_valid_i = 1; lu_issue_rd_i = 0;
    step();
    idle();
    checks++;
    if (rd_pending_o !== 32'h0) begin
      errors++;
      $display("FAIL sb_x0 got %h required 00000000", rd_pending_o);
    end
  endtask

  task automatic test_x0();
    idle();
    lu_valid_i = 1; lu_rd_i = 0; lu_data_i = 32'h55;
    #1;
    checks++;
    if (lu_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL x0_lu_ready got %b required 1", lu_ready_o);
    end
    step();
    idle();
    checks++;
    if (regfile_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_lu_write got we=%b required 0", regfile_wr_en_o);
    end
    pipe_valid_i = 1; pipe_wr_en_i = 1; pipe_rd_i = 0; pipe_data_i = 32'h66;
    #1;
    checks++;
    if (pipe_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL x0_pipe_ready got %b required 1", pipe_ready_o);
    end
    step();
    idle();
    checks++;
    if (regfile_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_pipe_write got we=%b required 0", regfile_wr_en_o);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    pipe_valid_i = 1; pipe_wr_en_i = 1;
    for (int c = 1; c <= 3; c++) begin
      pipe_rd_i = 5'(c); pipe_data_i = 32'hC0DE_0000 + c;
      step();
      checks++;
      if (regfile_wr_en_o !== 1'b1 || rd_addr_o !== 5'(c) || wb_data_o !== 32'hC0DE_0000 + c) begin
        errors++;
        $display("FAIL b2b_write cyc%0d got we=%b rd=%0d data=%h required 1/%0d/%h",
                 c, regfile_wr_en_o, rd_addr_o, wb_data_o, c, 32'hC0DE_0000 + c);
      end
    end
    idle();
    step();
  endtask

  initial begin
    idle();
    rst_ni = 0;
    test_reset();
    test_pipe_only();
    test_idle_slot();
    test_starvation();
    test_starve_clear();
    test_scoreboard();
    test_x0();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
